// File: rtl/mul_iter_if.sv
// Start/busy/done handshake and operand/result bus for the iterative multiplier.
// The EX stage drives the master side; mul_iter sits on the slave side.
interface mul_iter_if #(
   parameter int WIDTH = 32
);
   logic                 start;
   logic                 signed_op;
   logic                 cancel;
   logic [WIDTH-1:0]     operand_1;
   logic [WIDTH-1:0]     operand_2;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   result;

   modport master (
      output start, signed_op, cancel, operand_1, operand_2,
      input  busy, done, result
   );

   modport slave (
      input  start, signed_op, cancel, operand_1, operand_2,
      output busy, done, result
   );
endinterface

// File: rtl/mul_iter.sv
// Iterative radix-2^STEP shift-add multiplier, signed (MULT) and unsigned (MULTU).
// Works on magnitudes and applies the sign in a final FIX cycle; result = {HI, LO}.
//
// state | meaning
// IDLE  | waiting for start; done pulses here for one cycle after FIX
// CALC  | retiring STEP multiplier bits per cycle, N cycles total
// FIX   | apply sign to acc, write result, raise done
module mul_iter #(
   parameter int WIDTH = 32,
   parameter int STEP  = 2
) (
   input  logic      clk,
   input  logic      rst,
   mul_iter_if.slave bus
);
   localparam int N     = WIDTH / STEP;
   localparam int CNT_W = $clog2(N + 1);

   if (WIDTH < 4 || (WIDTH % 2) != 0 || !(STEP == 1 || STEP == 2 || STEP == 4) ||
       (WIDTH % STEP) != 0) begin : g_param_check
      $error("mul_iter: illegal WIDTH/STEP combination");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;

   logic [2*WIDTH-1:0] mcand_sh;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] pp;
   logic [2*WIDTH-1:0] result_q;
   logic [CNT_W-1:0]   cnt;
   logic               neg;
   logic               done_q;

   logic               go;
   logic               last;
   logic [WIDTH-1:0]   mag_1;
   logic [WIDTH-1:0]   mag_2;
   logic               neg_in;

   // cancel beats start when both arrive in IDLE
   assign go   = bus.start & ~bus.cancel;
   assign last = (cnt == CNT_W'(1));

   // most-negative value maps to 2^(WIDTH-1), which still fits unsigned
   assign mag_1  = (bus.signed_op && bus.operand_1[WIDTH-1]) ? (~bus.operand_1 + 1'b1)
                                                             : bus.operand_1;
   assign mag_2  = (bus.signed_op && bus.operand_2[WIDTH-1]) ? (~bus.operand_2 + 1'b1)
                                                             : bus.operand_2;
   assign neg_in = bus.signed_op & (bus.operand_1[WIDTH-1] ^ bus.operand_2[WIDTH-1]);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (go) begin
               state_nxt = CALC;
            end
         end
         CALC: begin
            if (bus.cancel) begin
               state_nxt = IDLE;
            end else if (last) begin
               state_nxt = FIX;
            end
         end
         FIX: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // partial product of the shifted multiplicand and the low STEP multiplier bits
   always_comb begin
      pp = '0;
      for (int j = 0; j < STEP; j++) begin
         if (mplier[j]) begin
            pp = pp + (mcand_sh << j);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mcand_sh <= '0;
         mplier   <= '0;
         acc      <= '0;
         cnt      <= '0;
         neg      <= 1'b0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (go) begin
                  mcand_sh <= {{WIDTH{1'b0}}, mag_1};
                  mplier   <= mag_2;
                  neg      <= neg_in;
                  acc      <= '0;
                  cnt      <= CNT_W'(N);
               end
            end
            CALC: begin
               if (!bus.cancel) begin
                  acc      <= acc + pp;
                  mcand_sh <= mcand_sh << STEP;
                  mplier   <= mplier >> STEP;
                  cnt      <= cnt - 1'b1;
               end
            end
            FIX: begin
               if (!bus.cancel) begin
                  result_q <= neg ? (~acc + 1'b1) : acc;
                  done_q   <= 1'b1;
               end
            end
            default: begin
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy   = (state == CALC) || (state == FIX);
   assign bus.done   = done_q;
   assign bus.result = result_q;
endmodule

// File: tb/tb_mul_iter.sv
// Directed bench for mul_iter: 32/2 default build plus 8/1 and 16/4 builds.
module tb_mul_iter;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   mul_iter_if #(.WIDTH(32)) b32 ();
   mul_iter_if #(.WIDTH(8))  b8  ();
   mul_iter_if #(.WIDTH(16)) b16 ();

   mul_iter #(.WIDTH(32), .STEP(2)) u_d32 (.clk(clk), .rst(rst), .bus(b32));
   mul_iter #(.WIDTH(8),  .STEP(1)) u_d8  (.clk(clk), .rst(rst), .bus(b8));
   mul_iter #(.WIDTH(16), .STEP(4)) u_d16 (.clk(clk), .rst(rst), .bus(b16));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_inputs(input int w, input logic st, input logic s,
                             input logic [31:0] a, input logic [31:0] b);
      case (w)
         0: begin
            b32.start = st; b32.signed_op = s; b32.operand_1 = a; b32.operand_2 = b;
         end
         1: begin
            b8.start = st; b8.signed_op = s; b8.operand_1 = a[7:0]; b8.operand_2 = b[7:0];
         end
         default: begin
            b16.start = st; b16.signed_op = s; b16.operand_1 = a[15:0]; b16.operand_2 = b[15:0];
         end
      endcase
   endtask

   task automatic set_start(input int w, input logic st);
      case (w)
         0:       b32.start = st;
         1:       b8.start  = st;
         default: b16.start = st;
      endcase
   endtask

   function automatic logic get_done(input int w);
      case (w)
         0:       return b32.done;
         1:       return b8.done;
         default: return b16.done;
      endcase
   endfunction

   function automatic logic get_busy(input int w);
      case (w)
         0:       return b32.busy;
         1:       return b8.busy;
         default: return b16.busy;
      endcase
   endfunction

   function automatic logic [63:0] get_result(input int w);
      case (w)
         0:       return b32.result;
         1:       return 64'(b8.result);
         default: return 64'(b16.result);
      endcase
   endfunction

   // reference product for the narrow builds (wid <= 16)
   function automatic logic [63:0] model(input int wid, input logic [31:0] a,
                                         input logic [31:0] b, input logic s);
      longint mask, sa, sb, p;
      mask = (longint'(1) << wid) - 1;
      sa = longint'(a) & mask;
      sb = longint'(b) & mask;
      if (s && sa[wid-1]) sa = sa - (longint'(1) << wid);
      if (s && sb[wid-1]) sb = sb - (longint'(1) << wid);
      p = sa * sb;
      return 64'(p) & ((64'd1 << (2*wid)) - 64'd1);
   endfunction

   // Start an op now, wait for done (bounded); returns in the done cycle so the
   // next call is a back-to-back start.
   task automatic run(input int w, input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [63:0] exp, input int lat, input string tag,
                      input int restart_at);
      int cyc;
      int busy_n;
      set_inputs(w, 1'b1, s, a, b);
      tick();
      set_start(w, 1'b0);
      cyc    = 0;
      busy_n = 0;
      while (!get_done(w) && cyc < 60) begin
         if (get_busy(w)) busy_n++;
         if (cyc == restart_at) set_inputs(w, 1'b1, ~s, ~a, b + 32'd1);
         tick();
         cyc++;
         if (cyc == restart_at + 1) set_start(w, 1'b0);
      end
      chk({tag, "_latency"}, 64'(cyc), 64'(lat));
      chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(lat));
      chk({tag, "_busy_at_done"}, 64'(get_busy(w)), 64'd0);
      chk({tag, "_result"}, get_result(w), exp);
   endtask

   initial begin
      int n;
      logic [31:0] ra, rb;
      logic        rs;

      rst = 1'b0;
      set_inputs(0, 1'b0, 1'b0, 32'd0, 32'd0);
      set_inputs(1, 1'b0, 1'b0, 32'd0, 32'd0);
      set_inputs(2, 1'b0, 1'b0, 32'd0, 32'd0);
      b32.cancel = 1'b0;
      b8.cancel  = 1'b0;
      b16.cancel = 1'b0;
      #12;
      chk("rst_busy", 64'(get_busy(0)), 64'd0);
      chk("rst_done", 64'(get_done(0)), 64'd0);
      chk("rst_result", get_result(0), 64'd0);
      chk("rst_result_w8", get_result(1), 64'd0);
      tick();
      rst = 1'b1;

      run(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 17, "umax", -1);
      tick();
      chk("done_one_cycle", 64'(get_done(0)), 64'd0);
      chk("result_hold", get_result(0), 64'hFFFF_FFFE_0000_0001);

      run(0, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 17, "neg3x7", -1);
      run(0, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 17, "minxmin", -1);
      run(0, 32'd5, 32'd7, 1'b0, 64'h23, 17, "restart_ignored", 5);
      chk("b2b_in_done_cycle", 64'(get_done(0)), 64'd1);
      run(0, 32'd12, 32'd10, 1'b0, 64'h78, 17, "b2b", -1);

      // start together with cancel in IDLE
      tick();
      set_inputs(0, 1'b1, 1'b0, 32'd9, 32'd9);
      b32.cancel = 1'b1;
      tick();
      set_start(0, 1'b0);
      b32.cancel = 1'b0;
      chk("cancel_beats_start", 64'(get_busy(0)), 64'd0);

      // cancel at cycle 8 of an op
      set_inputs(0, 1'b1, 1'b0, 32'h1234, 32'h5678);
      tick();
      set_start(0, 1'b0);
      repeat (8) tick();
      chk("busy_before_cancel", 64'(get_busy(0)), 64'd1);
      b32.cancel = 1'b1;
      tick();
      b32.cancel = 1'b0;
      chk("cancel_busy", 64'(get_busy(0)), 64'd0);
      chk("cancel_done", 64'(get_done(0)), 64'd0);
      n = 0;
      repeat (20) begin
         tick();
         if (get_done(0)) n++;
      end
      chk("cancel_no_done", 64'(n), 64'd0);
      chk("cancel_result_kept", get_result(0), 64'h78);
      run(0, 32'd2, 32'd3, 1'b0, 64'd6, 17, "after_cancel", -1);

      // asynchronous reset mid-CALC, between clock edges
      tick();
      set_inputs(0, 1'b1, 1'b0, 32'd5, 32'd5);
      tick();
      set_start(0, 1'b0);
      repeat (3) tick();
      chk("pre_rst_busy", 64'(get_busy(0)), 64'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_busy", 64'(get_busy(0)), 64'd0);
      chk("async_rst_done", 64'(get_done(0)), 64'd0);
      chk("async_rst_result", get_result(0), 64'd0);
      tick();
      tick();
      rst = 1'b1;
      n = 0;
      repeat (25) begin
         tick();
         if (get_done(0)) n++;
      end
      chk("post_rst_no_done", 64'(n), 64'd0);
      chk("post_rst_result", get_result(0), 64'd0);

      // WIDTH=8 STEP=1
      run(1, 32'h80, 32'h80, 1'b1, 64'h4000, 9, "w8_minxmin", -1);
      run(1, 32'hFF, 32'hFF, 1'b0, 64'hFE01, 9, "w8_umax", -1);
      run(1, 32'hFF, 32'h02, 1'b1, 64'hFFFE, 9, "w8_neg1x2", -1);
      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         run(1, ra, rb, rs, model(8, ra, rb, rs), 9, "w8_rand", -1);
      end

      // WIDTH=16 STEP=4
      run(2, 32'h8000, 32'h7FFF, 1'b1, 64'hC000_8000, 5, "w16_minxmax", -1);
      run(2, 32'hFFFF, 32'hFFFF, 1'b0, 64'hFFFE_0001, 5, "w16_umax", -1);
      run(2, 32'h0000, 32'h1234, 1'b1, 64'h0, 5, "w16_zero", -1);
      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         run(2, ra, rb, rs, model(16, ra, rb, rs), 5, "w16_rand", -1);
      end

      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
